// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for the sequential ALU.
//   start/aluop/a/b : request, driven by the master and sampled by the ALU in IDLE
//   busy            : high while a multi-cycle multiply is iterating
//   done            : one-cycle pulse, r/V/cout newly updated
//   r/V/cout        : result and flags, held until the next done
// Modports: master (requester side), slave (ALU side).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       aluop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             V;
    logic             cout;

    modport master (
        output start, aluop, a, b,
        input  busy, done, r, V, cout
    );

    modport slave (
        input  start, aluop, a, b,
        output busy, done, r, V, cout
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/done handshake, execute unit of the
// multi-cycle MIPS datapath.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_seq_if slave modport (start/aluop/a/b in; busy/done/r/V/cout out)
// Single-cycle ops (AND, OR, ADD, SUB, SLT, SLL, SRL) finish at the start edge.
// MUL is an unsigned shift-add multiply taking WIDTH further edges; busy is high
// meanwhile and any start seen during that time is dropped.
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SW    = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Single-cycle result, packed as {V, cout, r}. MUL never reaches here.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0] sum_v;
        logic [WIDTH:0] diff_v;
        logic           v_add;
        logic           v_sub;
        logic [WIDTH+1:0] res;
        sum_v  = {1'b0, x} + {1'b0, y};
        diff_v = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        v_add  = (x[WIDTH-1] == y[WIDTH-1]) && (sum_v[WIDTH-1] != x[WIDTH-1]);
        v_sub  = (x[WIDTH-1] != y[WIDTH-1]) && (diff_v[WIDTH-1] != x[WIDTH-1]);
        case (op)
            OP_AND:  res = {2'b00, x & y};
            OP_OR:   res = {2'b00, x | y};
            OP_ADD:  res = {v_add, sum_v};
            OP_SUB:  res = {v_sub, diff_v};
            // Sign of the difference corrected by overflow gives the true signed compare.
            OP_SLT:  res = {2'b00, {(WIDTH-1){1'b0}}, diff_v[WIDTH-1] ^ v_sub};
            OP_SLL:  res = {2'b00, x << y[SW-1:0]};
            OP_SRL:  res = {2'b00, x >> y[SW-1:0]};
            default: res = {(WIDTH+2){1'b0}};
        endcase
        return res;
    endfunction

    state_t             state_r,  state_s;
    logic [2*WIDTH-1:0] mcand_r,  mcand_s;
    logic [WIDTH-1:0]   mplier_r, mplier_s;
    logic [2*WIDTH-1:0] acc_r,    acc_s;
    logic [SW-1:0]      cnt_r,    cnt_s;
    logic [WIDTH-1:0]   r_r,      r_s;
    logic               v_r,      v_s;
    logic               cout_r,   cout_s;
    logic               busy_r,   busy_s;
    logic               done_r,   done_s;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [WIDTH+1:0]   eval_s;

    // Next-state and next-value logic for the FSM and datapath registers.
    always_comb begin
        state_s    = state_r;
        mcand_s    = mcand_r;
        mplier_s   = mplier_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        r_s        = r_r;
        v_s        = v_r;
        cout_s     = cout_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        eval_s     = alu_eval(bus.aluop, bus.a, bus.b);

        // Partial-product accumulation for the current multiply iteration.
        if (mplier_r[0]) begin
            acc_step_s = acc_r + mcand_r;
        end else begin
            acc_step_s = acc_r;
        end

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.aluop == OP_MUL) begin
                        mcand_s  = {{WIDTH{1'b0}}, bus.a};
                        mplier_s = bus.b;
                        acc_s    = {(2*WIDTH){1'b0}};
                        cnt_s    = {SW{1'b0}};
                        busy_s   = 1'b1;
                        state_s  = MUL;
                    end else begin
                        r_s      = eval_s[WIDTH-1:0];
                        cout_s   = eval_s[WIDTH];
                        v_s      = eval_s[WIDTH+1];
                        done_s   = 1'b1;
                        state_s  = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                acc_s    = acc_step_s;
                mcand_s  = mcand_r << 1;
                mplier_s = mplier_r >> 1;
                cnt_s    = cnt_r + {{(SW-1){1'b0}}, 1'b1};
                // Last iteration: publish the freshly accumulated product.
                if (cnt_r == SW'(WIDTH-1)) begin
                    r_s     = acc_step_s[WIDTH-1:0];
                    v_s     = |acc_step_s[2*WIDTH-1:WIDTH];
                    cout_s  = 1'b0;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = MUL;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {SW{1'b0}};
            r_r      <= {WIDTH{1'b0}};
            v_r      <= 1'b0;
            cout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            r_r      <= r_s;
            v_r      <= v_s;
            cout_r   <= cout_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign bus.r    = r_r;
    assign bus.V    = v_r;
    assign bus.cout = cout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized check of alu_seq at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
module tb_alu_seq;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] last_r;
    logic [65:0] exp_v;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus32 ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    // Reference: {V, cout, r} from plain integer arithmetic on w-bit values.
    function automatic logic [65:0] model(input logic [2:0] op, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input int w);
        logic [63:0] mask, a, b, s, r;
        logic v, c;
        longint sa, sb, sres, hi, lo;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        hi = (longint'(1) << (w-1)) - 1;
        lo = -hi - 1;
        sh = int'(b % 64'(w));
        r = 64'd0; v = 1'b0; c = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin s = a + b; r = s & mask; c = s[w]; sres = sa + sb; v = (sres > hi) || (sres < lo); end
            OP_SUB: begin r = (a - b) & mask; c = (a >= b); sres = sa - sb; v = (sres > hi) || (sres < lo); end
            OP_SLT: r = (sa < sb) ? 64'd1 : 64'd0;
            OP_SLL: r = (a << sh) & mask;
            OP_SRL: r = a >> sh;
            OP_MUL: begin s = a * b; r = s & mask; v = (s >> w) != 64'd0; end
            default: r = 64'd0;
        endcase
        return {v, c, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit w8, input logic st, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w8) begin
            bus8.start = st; bus8.aluop = op; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus32.start = st; bus32.aluop = op; bus32.a = a[31:0]; bus32.b = b[31:0];
        end
    endtask

    // {busy, done, V, cout}
    function automatic logic [3:0] flags(input bit w8);
        return w8 ? {bus8.busy, bus8.done, bus8.V, bus8.cout}
                  : {bus32.busy, bus32.done, bus32.V, bus32.cout};
    endfunction

    function automatic logic [63:0] obs_r(input bit w8);
        return w8 ? 64'(bus8.r) : 64'(bus32.r);
    endfunction

    // Issue one op, wait (bounded) for done, check latency, busy time and result.
    task automatic do_op(input bit w8, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input string tag);
        logic [65:0] e;
        logic [3:0]  f;
        int w, k, busy_n;
        w = w8 ? 8 : 32;
        e = model(op, a, b, w);
        @(negedge clk);
        drive(w8, 1'b1, op, a, b);
        @(negedge clk);
        drive(w8, 1'b0, 3'($urandom), 64'($urandom), 64'($urandom));
        k = 1;
        busy_n = 0;
        while (!flags(w8)[2] && k <= 200) begin
            if (flags(w8)[3]) busy_n++;
            @(negedge clk);
            k++;
        end
        f = flags(w8);
        last_r = obs_r(w8);
        chk({tag, "_done_edge"}, 64'(k - 1), (op == OP_MUL) ? 64'(w) : 64'd0);
        chk({tag, "_busy_cycles"}, 64'(busy_n), (op == OP_MUL) ? 64'(w) : 64'd0);
        chk({tag, "_busy_at_done"}, 64'(f[3]), 64'd0);
        chk({tag, "_r"}, last_r, e[63:0]);
        chk({tag, "_cout"}, 64'(f[0]), 64'(e[64]));
        chk({tag, "_V"}, 64'(f[1]), 64'(e[65]));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int k, n_done, first_k;
        logic [63:0] r_at_done;
        drive(1'b0, 1'b0, OP_AND, 64'd0, 64'd0);
        drive(1'b1, 1'b0, OP_AND, 64'd0, 64'd0);
        #1 rst = 1'b1;
        #2;
        chk("rst32_flags", 64'(flags(1'b0)), 64'd0);
        chk("rst32_r", obs_r(1'b0), 64'd0);
        chk("rst8_flags", 64'(flags(1'b1)), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD overflow, SUB with and without borrow
        do_op(1'b0, OP_ADD, 64'h7FFFFFFF, 64'h1, "add_ovf");
        chk("add_ovf_const", last_r, 64'h80000000);
        do_op(1'b0, OP_SUB, 64'd7, 64'd5, "sub_pos");
        do_op(1'b0, OP_SUB, 64'd5, 64'd7, "sub_neg");
        chk("sub_neg_const", last_r, 64'hFFFFFFFE);

        // Three SLTs back to back: one done pulse per cycle
        @(negedge clk);
        drive(1'b0, 1'b1, OP_SLT, 64'd0, 64'hAAE1AAB5);
        @(negedge clk);
        chk("slt0_done", 64'(flags(1'b0)[2]), 64'd1);
        chk("slt0_r", obs_r(1'b0), 64'd0);
        drive(1'b0, 1'b1, OP_SLT, 64'hAAE1AAB5, 64'd0);
        @(negedge clk);
        chk("slt1_done", 64'(flags(1'b0)[2]), 64'd1);
        chk("slt1_r", obs_r(1'b0), 64'd1);
        drive(1'b0, 1'b1, OP_SLT, 64'h80000000, 64'd1);
        @(negedge clk);
        chk("slt2_done", 64'(flags(1'b0)[2]), 64'd1);
        chk("slt2_r", obs_r(1'b0), 64'd1);
        drive(1'b0, 1'b0, OP_AND, 64'd0, 64'd0);
        @(negedge clk);
        chk("slt_done_drop", 64'(flags(1'b0)[2]), 64'd0);

        // Logic and shifts
        do_op(1'b0, OP_AND, 64'h5B9CD554, 64'hAAE1AAB5, "and");
        chk("and_const", last_r, 64'h0A808014);
        do_op(1'b0, OP_OR, 64'h0000F0F0, 64'h0F0F0000, "or");
        do_op(1'b0, OP_SLL, 64'd1, 64'd31, "sll");
        chk("sll_const", last_r, 64'h80000000);
        do_op(1'b0, OP_SRL, 64'h80000000, 64'h24, "srl");
        chk("srl_const", last_r, 64'h08000000);

        // MUL with an ADD start issued mid-multiply, which must be dropped
        exp_v = model(OP_MUL, 64'd12345, 64'd100, 32);
        @(negedge clk);
        drive(1'b0, 1'b1, OP_MUL, 64'd12345, 64'd100);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_AND, 64'd0, 64'd0);
        n_done = 0; first_k = 0; r_at_done = 64'd0;
        for (k = 1; k <= 45; k++) begin
            if (flags(1'b0)[2]) begin
                n_done++;
                if (first_k == 0) begin
                    first_k = k;
                    r_at_done = obs_r(1'b0);
                end
            end
            if (k == 6) drive(1'b0, 1'b1, OP_ADD, 64'd1, 64'd1);
            else if (k == 7) drive(1'b0, 1'b0, OP_AND, 64'd0, 64'd0);
            @(negedge clk);
        end
        chk("mul_ign_ndone", 64'(n_done), 64'd1);
        chk("mul_ign_edge", 64'(first_k - 1), 64'd32);
        chk("mul_ign_r", r_at_done, exp_v[63:0]);
        chk("mul_ign_const", r_at_done, 64'h0012D644);
        do_op(1'b0, OP_MUL, 64'h00010000, 64'h00010000, "mul_hi");
        chk("mul_hi_const", last_r, 64'd0);

        // Reset in the middle of a MUL
        @(negedge clk);
        drive(1'b0, 1'b1, OP_MUL, 64'd12345, 64'd100);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_AND, 64'd0, 64'd0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_flags", 64'(flags(1'b0)), 64'd0);
        chk("rst_mid_r", obs_r(1'b0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, OP_ADD, 64'd1, 64'd1, "add_after_rst");
        n_done = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (flags(1'b0)[2]) n_done++;
        end
        chk("no_stale_mul", 64'(n_done), 64'd0);

        // WIDTH=8 instance
        do_op(1'b1, OP_MUL, 64'h0F, 64'h11, "mul8");
        chk("mul8_const", last_r, 64'hFF);
        do_op(1'b1, OP_ADD, 64'h80, 64'h80, "add8");

        // Randomized ops on both widths
        for (int i = 0; i < 40; i++) begin
            do_op(1'b0, 3'($urandom), 64'($urandom), 64'($urandom), $sformatf("rnd32_%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            do_op(1'b1, 3'($urandom), 64'($urandom), 64'($urandom), $sformatf("rnd8_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, start/done-handshaked ALU that generalises the 32-bit combinational ALU to a parametrised WIDTH.
- Keeps the existing aluop encodings for AND, OR, ADD, SUB and SLT, together with the overflow and carry flags.
- Adds three ops in the spare aluop codes: an iterative multi-cycle multiply, a logical shift-left and a logical shift-right.
- Serves as the execute unit of the multi-cycle MIPS datapath, where an op may take more than one clock.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 4.
- SW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- aluop  input  3  operation code, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while a MUL is iterating.
- done  output  1  one-cycle pulse: r/V/cout valid and newly updated.
- r  output  WIDTH  result; holds until the next done.
- V  output  1  overflow flag; holds with r.
- cout  output  1  carry out of bit WIDTH-1; holds with r.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, r=0, V=0, cout=0; internal accumulator, counter and operand registers all cleared. Applies instantly, including mid-MUL. The aborted op never produces done.
- aluop 000 AND: r = a & b; V=0, cout=0.
- aluop 001 OR: r = a | b; V=0, cout=0.
- aluop 010 ADD: {cout,r} = a + b. V = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
- aluop 110 SUB: {cout,r} = a + ~b + 1. cout=1 means no borrow. V = (a[W-1]!=b[W-1]) && (r[W-1]!=a[W-1]).
- aluop 111 SLT (signed): compute the SUB internally, then r = {0..., diff[W-1]^Vsub}. V=0, cout=0. This result is correct even when the subtract overflows.
- aluop 100 SLL: r = a << b[SW-1:0]; V=0, cout=0.
- aluop 101 SRL: r = a >> b[SW-1:0], zero fill; V=0, cout=0.
- aluop 011 MUL (unsigned, shift-add):
  - r = low WIDTH bits of a*b.
  - V = 1 if the upper WIDTH bits of the 2*WIDTH product are nonzero; cout=0.
- FSM has two states, IDLE and MUL.
- IDLE, start=1 with any non-MUL op:
  - At that edge, r/V/cout load the result and done=1 for exactly one cycle.
  - State stays IDLE, so latency is 1 cycle.
  - Back-to-back starts give one result per cycle.
- IDLE, start=1 with aluop=011:
  - At that edge, latch a into mcand (2*WIDTH, zero-extended) and b into mplier; acc=0, cnt=0, busy=1, state=MUL.
  - r/V/cout keep their previous values.
- MUL, each edge:
  - If mplier[0], acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt += 1.
- MUL, on the edge where cnt==WIDTH-1:
  - The final iteration completes.
  - r = final acc[W-1:0], V = |final acc[2W-1:W], cout=0.
  - done=1, busy=0, state=IDLE.
  - Total latency is WIDTH cycles from the start edge to visible done.
- start while busy=1 is ignored; no queueing, and inputs are not sampled.
- start on the cycle done is high is accepted normally.
- Inputs a, b and aluop may change freely after the sampling edge without affecting the op in flight.
- Undefined or X aluop is not supported. All 8 codes are defined, so there is no illegal encoding.
- done is high only for the single cycle following the completing edge.

Test Plan (WIDTH=32 unless noted):
- ADD a=0x7FFFFFFF, b=0x00000001, start 1 cycle -> next cycle done=1, r=0x80000000, V=1, cout=0. Then SUB a=7, b=5 -> r=2, cout=1, V=0. Then SUB a=5, b=7 -> r=0xFFFFFFFE, cout=0, V=0.
- SLT a=0, b=0xAAE1AAB5 -> r=0. Swapped operands -> r=1. a=0x80000000, b=0x00000001 (subtract overflows) -> r=1. Issued on consecutive cycles -> three consecutive done pulses.
- AND 0x5B9CD554 & 0xAAE1AAB5 -> r=0x0A808014. OR 0x0000F0F0 | 0x0F0F0000 -> r=0x0F0FF0F0. SLL a=1, b=31 -> r=0x80000000. SRL a=0x80000000, b=0x24 (shamt 4) -> r=0x08000000.
- MUL a=12345, b=100 -> busy=1 for 32 cycles, done exactly 32 cycles after start, r=0x0012D644, V=0. A start pulse during busy (e.g. ADD) must be ignored and produce no extra done. MUL a=0x00010000, b=0x00010000 -> r=0, V=1.
- Reset mid-MUL: assert rst at cycle 10 of a MUL -> busy=0, done=0, r=0 immediately. After release, an ADD 1+1 -> r=2, done after 1 cycle, with no stale MUL result appearing.
- WIDTH=8 instance: MUL 0x0F*0x11 -> r=0xFF, V=0, latency 8 cycles. ADD 0x80+0x80 -> r=0x00, cout=1, V=1.
